dec_fpr_wb_ctl: RTL and testbench

- Write-side controller for the 32-entry floating-point register file.
- Collects FP results from three producers:
  - the fixed-latency FPU pipe;
  - the iterative divide/sqrt unit (valid/ready);
  - FP load returns (non-blocking, buffered).
- Drives two register-file write ports (port0, port1), never to the same register in one cycle.
- Keeps a per-register pending-write scoreboard that decode uses for RAW/WAW stalls.

---
 rtl/dec_fpr_pkg.sv | 13 +
 rtl/dec_fpr_ldq.sv | 65 ++++++
 rtl/dec_fpr_wb_ctl.sv | 147 ++++++++++++++
 tb/tb_dec_fpr_wb_ctl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_fpr_pkg.sv
// Shared types and widths for the floating-point register-file writeback path.
package dec_fpr_pkg;

    localparam int unsigned FPR_NUM    = 32;
    localparam int unsigned FPR_ADDR_W = 5;
    localparam int unsigned FPR_DATA_W = 32;

    typedef struct packed {
        logic [FPR_ADDR_W-1:0] rd;
        logic [FPR_DATA_W-1:0] data;
    } fpr_wb_t;

endpackage

// File: rtl/dec_fpr_ldq.sv
// FP load-return buffer: small FIFO of {rd, data} with registered full/empty
// flags and a sticky overflow flag for pushes that do not fit.
module dec_fpr_ldq
    import dec_fpr_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    i_push,
    input  fpr_wb_t i_data,
    input  logic    i_pop,
    output fpr_wb_t o_head,
    output logic    o_full,
    output logic    o_empty,
    output logic    o_overflow
);

    localparam int unsigned CNT_W = PTR_W + 1;

    fpr_wb_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic             r_overflow;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic [CNT_W-1:0] w_count_nxt;

    // A push into a full buffer only fits when the head leaves in the same cycle.
    assign w_pop_ok    = i_pop && !r_empty;
    assign w_push_ok   = i_push && (!r_full || w_pop_ok);
    assign w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            if (i_push && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head     = r_mem[r_rd_ptr];
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/dec_fpr_wb_ctl.sv
// FP register-file write controller: FPU on port0, load buffer and divide
// arbitrated onto port1, plus the per-register pending-write scoreboard.
module dec_fpr_wb_ctl
    import dec_fpr_pkg::*;
#(
    parameter int unsigned LDQ_DEPTH  = 4,
    parameter int unsigned LDQ_PTR_W  = 2,
    parameter int unsigned DIV_STARVE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  iss_valid,
    input  logic [FPR_ADDR_W-1:0] iss_rd,
    input  logic                  fpu_valid,
    input  logic [FPR_ADDR_W-1:0] fpu_rd,
    input  logic [FPR_DATA_W-1:0] fpu_data,
    input  logic                  div_valid,
    input  logic [FPR_ADDR_W-1:0] div_rd,
    input  logic [FPR_DATA_W-1:0] div_data,
    output logic                  div_ready,
    input  logic                  ld_valid,
    input  logic [FPR_ADDR_W-1:0] ld_rd,
    input  logic [FPR_DATA_W-1:0] ld_data,
    output logic                  ld_full,
    output logic                  wen0,
    output logic [FPR_ADDR_W-1:0] waddr0,
    output logic [FPR_DATA_W-1:0] wd0,
    output logic                  wen1,
    output logic [FPR_ADDR_W-1:0] waddr1,
    output logic [FPR_DATA_W-1:0] wd1,
    output logic [FPR_NUM-1:0]    fpr_busy,
    output logic                  ldq_overflow
);

    localparam int unsigned STARVE_W = $clog2(DIV_STARVE + 1);

    fpr_wb_t               w_ld_in;
    fpr_wb_t               w_ld_head;
    fpr_wb_t               w_div_wb;
    fpr_wb_t               w_p1_sel;
    logic                  w_ld_empty;
    logic                  w_div_pref;
    logic                  w_ld_pref;
    logic                  w_conflict;
    logic                  w_div_win;
    logic                  w_ld_win;
    logic [FPR_NUM-1:0]    w_busy_nxt;
    logic [STARVE_W-1:0]   r_starve;
    logic                  r_wen0;
    logic [FPR_ADDR_W-1:0] r_waddr0;
    logic [FPR_DATA_W-1:0] r_wd0;
    logic                  r_wen1;
    logic [FPR_ADDR_W-1:0] r_waddr1;
    logic [FPR_DATA_W-1:0] r_wd1;
    logic [FPR_NUM-1:0]    r_busy;

    assign w_ld_in  = '{rd: ld_rd, data: ld_data};
    assign w_div_wb = '{rd: div_rd, data: div_data};

    dec_fpr_ldq #(
        .DEPTH (LDQ_DEPTH),
        .PTR_W (LDQ_PTR_W)
    ) u_ldq (
        .clk        (clk),
        .rst        (rst),
        .i_push     (ld_valid),
        .i_data     (w_ld_in),
        .i_pop      (w_ld_win),
        .o_head     (w_ld_head),
        .o_full     (ld_full),
        .o_empty    (w_ld_empty),
        .o_overflow (ldq_overflow)
    );

    // Port1 select: load head by default, divide once starved or when nothing
    // is buffered; a same-register clash with the FPU idles port1 this cycle.
    always_comb begin
        w_div_pref = div_valid && ((r_starve == STARVE_W'(DIV_STARVE)) || w_ld_empty);
        w_ld_pref  = !w_ld_empty && !w_div_pref;
        w_p1_sel   = w_div_pref ? w_div_wb : w_ld_head;
        w_conflict = fpu_valid && (w_div_pref || w_ld_pref) && (w_p1_sel.rd == fpu_rd);
        w_div_win  = !rst && w_div_pref && !w_conflict;
        w_ld_win   = !rst && w_ld_pref && !w_conflict;
    end

    assign div_ready = w_div_win;

    // Retiring writes clear their bit; a same-cycle issue re-sets it.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_wen0) w_busy_nxt[r_waddr0] = 1'b0;
        if (r_wen1) w_busy_nxt[r_waddr1] = 1'b0;
        if (iss_valid) w_busy_nxt[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= '0;
        end else if (div_valid && !w_div_win) begin
            if (r_starve != STARVE_W'(DIV_STARVE)) r_starve <= r_starve + STARVE_W'(1);
        end else begin
            r_starve <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen0   <= 1'b0;
            r_waddr0 <= '0;
            r_wd0    <= '0;
            r_wen1   <= 1'b0;
            r_waddr1 <= '0;
            r_wd1    <= '0;
            r_busy   <= '0;
        end else begin
            r_wen0 <= fpu_valid;
            if (fpu_valid) begin
                r_waddr0 <= fpu_rd;
                r_wd0    <= fpu_data;
            end
            r_wen1 <= w_div_win || w_ld_win;
            if (w_div_win || w_ld_win) begin
                r_waddr1 <= w_p1_sel.rd;
                r_wd1    <= w_p1_sel.data;
            end
            r_busy <= w_busy_nxt;
        end
    end

    assign wen0     = r_wen0;
    assign waddr0   = r_waddr0;
    assign wd0      = r_wd0;
    assign wen1     = r_wen1;
    assign waddr1   = r_waddr1;
    assign wd1      = r_wd1;
    assign fpr_busy = r_busy;

    // Decode stalls on a pending register unless its write retires this cycle.
    a_issue_not_busy: assert property (@(posedge clk) disable iff (rst)
        !(iss_valid && r_busy[iss_rd]
          && !(r_wen0 && (r_waddr0 == iss_rd))
          && !(r_wen1 && (r_waddr1 == iss_rd))));

    a_ports_distinct: assert property (@(posedge clk) disable iff (rst)
        !(r_wen0 && r_wen1 && (r_waddr0 == r_waddr1)));

endmodule

// File: tb/tb_dec_fpr_wb_ctl.sv
// Bench for dec_fpr_wb_ctl: directed vector table, reset sequence, then
// random traffic against a queue-based reference model.
module tb_dec_fpr_wb_ctl;
    import dec_fpr_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned STARVE = 4;
    localparam int unsigned NRAND  = 3000;

    typedef struct packed {
        logic        iss_v;
        logic [4:0]  iss_rd;
        logic        fpu_v;
        logic [4:0]  fpu_rd;
        logic [31:0] fpu_d;
        logic        div_v;
        logic [4:0]  div_rd;
        logic [31:0] div_d;
        logic        ld_v;
        logic [4:0]  ld_rd;
        logic [31:0] ld_d;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        x_rdy;
        logic        x_wen0;
        logic [4:0]  x_a0;
        logic [31:0] x_d0;
        logic        x_wen1;
        logic [4:0]  x_a1;
        logic [31:0] x_d1;
        logic [31:0] x_busy;
        logic        x_full;
        logic        x_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        fpu_valid;
    logic [4:0]  fpu_rd;
    logic [31:0] fpu_data;
    logic        div_valid;
    logic [4:0]  div_rd;
    logic [31:0] div_data;
    logic        div_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_full;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wd0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [31:0] wd1;
    logic [31:0] fpr_busy;
    logic        ldq_overflow;

    dec_fpr_wb_ctl #(
        .LDQ_DEPTH  (DEPTH),
        .LDQ_PTR_W  (2),
        .DIV_STARVE (STARVE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .fpu_valid    (fpu_valid),
        .fpu_rd       (fpu_rd),
        .fpu_data     (fpu_data),
        .div_valid    (div_valid),
        .div_rd       (div_rd),
        .div_data     (div_data),
        .div_ready    (div_ready),
        .ld_valid     (ld_valid),
        .ld_rd        (ld_rd),
        .ld_data      (ld_data),
        .ld_full      (ld_full),
        .wen0         (wen0),
        .waddr0       (waddr0),
        .wd0          (wd0),
        .wen1         (wen1),
        .waddr1       (waddr1),
        .wd1          (wd1),
        .fpr_busy     (fpr_busy),
        .ldq_overflow (ldq_overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, " wen0"},      32'(wen0), 32'd0);
        chk({pfx, " waddr0"},    32'(waddr0), 32'd0);
        chk({pfx, " wd0"},       wd0, 32'd0);
        chk({pfx, " wen1"},      32'(wen1), 32'd0);
        chk({pfx, " waddr1"},    32'(waddr1), 32'd0);
        chk({pfx, " wd1"},       wd1, 32'd0);
        chk({pfx, " busy"},      fpr_busy, 32'd0);
        chk({pfx, " ld_full"},   32'(ld_full), 32'd0);
        chk({pfx, " overflow"},  32'(ldq_overflow), 32'd0);
        chk({pfx, " div_ready"}, 32'(div_ready), 32'd0);
    endtask

    task automatic drive(input stim_t s);
        iss_valid = s.iss_v;  iss_rd   = s.iss_rd;
        fpu_valid = s.fpu_v;  fpu_rd   = s.fpu_rd;  fpu_data = s.fpu_d;
        div_valid = s.div_v;  div_rd   = s.div_rd;  div_data = s.div_d;
        ld_valid  = s.ld_v;   ld_rd    = s.ld_rd;   ld_data  = s.ld_d;
    endtask

    function automatic stim_t mk(input bit iv, input int unsigned ir,
                                 input bit fv, input int unsigned fr, input logic [31:0] fd,
                                 input bit dv, input int unsigned dr, input logic [31:0] dd,
                                 input bit lv, input int unsigned lr, input logic [31:0] ld);
        stim_t s;
        s.iss_v = iv; s.iss_rd = 5'(ir);
        s.fpu_v = fv; s.fpu_rd = 5'(fr); s.fpu_d = fd;
        s.div_v = dv; s.div_rd = 5'(dr); s.div_d = dd;
        s.ld_v  = lv; s.ld_rd  = 5'(lr); s.ld_d  = ld;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input bit rdy,
                                 input bit w0, input int unsigned a0, input logic [31:0] d0,
                                 input bit w1, input int unsigned a1, input logic [31:0] d1,
                                 input logic [31:0] busy, input bit full, input bit ovf);
        vec_t v;
        v.s = s; v.x_rdy = rdy;
        v.x_wen0 = w0; v.x_a0 = 5'(a0); v.x_d0 = d0;
        v.x_wen1 = w1; v.x_a1 = 5'(a1); v.x_d1 = d1;
        v.x_busy = busy; v.x_full = full; v.x_ovf = ovf;
        return v;
    endfunction

    vec_t vecs[$];

    // Reference-model state for the random phase
    fpr_wb_t     mq[$];
    fpr_wb_t     ment;
    int          starve_m;
    logic [31:0] busy_m;
    bit          ovf_m, full_m;
    bit          pw0, pw1;
    logic [4:0]  pa0, pa1;
    logic [31:0] pd0, pd1;
    bit          dpend;
    logic [4:0]  drd;
    logic [31:0] dd;
    stim_t       rs;
    bit          m_empty, m_dpref, m_lpref, m_conf, m_dwin, m_lwin;
    logic [4:0]  m_rd;

    initial begin
        stim_t idle;
        idle = '0;

        // Port0, scoreboard, FPU/port1 conflicts, set-beats-clear
        vecs.push_back(mkv(mk(1,3, 0,0,0, 0,0,0, 0,0,0),                  0, 0,0,0, 0,0,0, 32'h0000_0008, 0,0));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 0,0,0, 32'h0000_0008, 0,0));
        vecs.push_back(mkv(mk(0,0, 1,3,32'h3F80_0000, 0,0,0, 0,0,0),      0, 1,3,32'h3F80_0000, 0,0,0, 32'h0000_0008, 0,0));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 0,0,0, 32'h0, 0,0));
        vecs.push_back(mkv(mk(0,0, 0,0,0, 0,0,0, 1,9,32'h99),             0, 0,0,0, 0,0,0, 32'h0, 0,0));
        vecs.push_back(mkv(mk(0,0, 1,9,32'h11, 0,0,0, 0,0,0),             0, 1,9,32'h11, 0,0,0, 32'h0, 0,0));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 1,9,32'h99, 32'h0, 0,0));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 0,0,0, 32'h0, 0,0));
        vecs.push_back(mkv(mk(0,0, 1,9,32'h22, 1,9,32'hD9, 0,0,0),        0, 1,9,32'h22, 0,0,0, 32'h0, 0,0));
        vecs.push_back(mkv(mk(0,0, 0,0,0, 1,9,32'hD9, 0,0,0),             1, 0,0,0, 1,9,32'hD9, 32'h0, 0,0));
        vecs.push_back(mkv(mk(1,12, 0,0,0, 0,0,0, 1,12,32'hC),            0, 0,0,0, 0,0,0, 32'h0000_1000, 0,0));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 1,12,32'hC, 32'h0000_1000, 0,0));
        vecs.push_back(mkv(mk(1,12, 0,0,0, 0,0,0, 0,0,0),                 0, 0,0,0, 0,0,0, 32'h0000_1000, 0,0));
        vecs.push_back(mkv(mk(0,0, 1,12,32'h12, 0,0,0, 0,0,0),            0, 1,12,32'h12, 0,0,0, 32'h0000_1000, 0,0));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 0,0,0, 32'h0, 0,0));
        // Fill the buffer (FPU clash on rd4 blocks pops), overflow, then divide starvation
        vecs.push_back(mkv(mk(0,0, 0,0,0, 0,0,0, 1,4,32'h40),             0, 0,0,0, 0,0,0, 32'h0, 0,0));
        vecs.push_back(mkv(mk(0,0, 1,4,32'hF4, 0,0,0, 1,5,32'h50),        0, 1,4,32'hF4, 0,0,0, 32'h0, 0,0));
        vecs.push_back(mkv(mk(0,0, 1,4,32'hF4, 0,0,0, 1,6,32'h60),        0, 1,4,32'hF4, 0,0,0, 32'h0, 0,0));
        vecs.push_back(mkv(mk(0,0, 1,4,32'hF4, 0,0,0, 1,7,32'h70),        0, 1,4,32'hF4, 0,0,0, 32'h0, 1,0));
        vecs.push_back(mkv(mk(0,0, 1,4,32'hF4, 0,0,0, 1,8,32'h80),        0, 1,4,32'hF4, 0,0,0, 32'h0, 1,1));
        vecs.push_back(mkv(mk(0,0, 0,0,0, 1,20,32'hD20, 1,24,32'h240),    0, 0,0,0, 1,4,32'h40, 32'h0, 1,1));
        vecs.push_back(mkv(mk(0,0, 0,0,0, 1,20,32'hD20, 1,25,32'h250),    0, 0,0,0, 1,5,32'h50, 32'h0, 1,1));
        vecs.push_back(mkv(mk(0,0, 0,0,0, 1,20,32'hD20, 1,26,32'h260),    0, 0,0,0, 1,6,32'h60, 32'h0, 1,1));
        vecs.push_back(mkv(mk(0,0, 0,0,0, 1,20,32'hD20, 1,27,32'h270),    0, 0,0,0, 1,7,32'h70, 32'h0, 1,1));
        vecs.push_back(mkv(mk(0,0, 0,0,0, 1,20,32'hD20, 0,0,0),           1, 0,0,0, 1,20,32'hD20, 32'h0, 1,1));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 1,24,32'h240, 32'h0, 0,1));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 1,25,32'h250, 32'h0, 0,1));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 1,26,32'h260, 32'h0, 0,1));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 1,27,32'h270, 32'h0, 0,1));
        vecs.push_back(mkv(idle,                                           0, 0,0,0, 0,0,0, 32'h0, 0,1));

        rst = 1'b1;
        drive(idle);
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].s);
            #1;
            chk($sformatf("v%0d div_ready", i), 32'(div_ready), 32'(vecs[i].x_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d wen0", i), 32'(wen0), 32'(vecs[i].x_wen0));
            if (vecs[i].x_wen0) begin
                chk($sformatf("v%0d waddr0", i), 32'(waddr0), 32'(vecs[i].x_a0));
                chk($sformatf("v%0d wd0", i), wd0, vecs[i].x_d0);
            end
            chk($sformatf("v%0d wen1", i), 32'(wen1), 32'(vecs[i].x_wen1));
            if (vecs[i].x_wen1) begin
                chk($sformatf("v%0d waddr1", i), 32'(waddr1), 32'(vecs[i].x_a1));
                chk($sformatf("v%0d wd1", i), wd1, vecs[i].x_d1);
            end
            chk($sformatf("v%0d busy", i), fpr_busy, vecs[i].x_busy);
            chk($sformatf("v%0d ld_full", i), 32'(ld_full), 32'(vecs[i].x_full));
            chk($sformatf("v%0d overflow", i), 32'(ldq_overflow), 32'(vecs[i].x_ovf));
        end

        // Mid-stream reset with two loads buffered and busy = 0x1010
        drive(mk(1,4, 0,0,0, 0,0,0, 0,0,0));
        @(posedge clk); #1;
        drive(mk(1,12, 0,0,0, 0,0,0, 1,20,32'h200));
        @(posedge clk); #1;
        drive(mk(0,0, 1,20,32'hF20, 0,0,0, 1,21,32'h210));
        @(posedge clk); #1;
        chk("pre-reset busy", fpr_busy, 32'h0000_1010);
        chk("pre-reset wen0", 32'(wen0), 32'd1);
        drive(mk(0,0, 1,20,32'hF20, 1,30,32'h300, 0,0,0));
        #1;
        rst = 1'b1;
        #1;
        chk_zero("mid-reset");
        drive(idle);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(mk(0,0, 0,0,0, 1,30,32'h300, 0,0,0));
        #1;
        chk("post-reset div_ready", 32'(div_ready), 32'd1);
        @(posedge clk); #1;
        chk("post-reset wen1", 32'(wen1), 32'd1);
        chk("post-reset waddr1", 32'(waddr1), 32'd30);
        chk("post-reset wd1", wd1, 32'h300);
        chk("post-reset busy", fpr_busy, 32'd0);
        chk("post-reset ld_full", 32'(ld_full), 32'd0);
        drive(idle);
        @(posedge clk); #1;
        chk("post-reset idle wen1", 32'(wen1), 32'd0);
        @(posedge clk); #1;

        // Random traffic against the queue model
        starve_m = 0; busy_m = '0; ovf_m = 0; full_m = 0;
        pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        dpend = 0; drd = '0; dd = '0;
        for (int c = 0; c < NRAND; c++) begin
            rs = '0;
            if (!dpend && ($urandom_range(0, 2) == 0)) begin
                dpend = 1;
                drd   = 5'($urandom_range(0, 7));
                dd    = $urandom;
            end
            rs.div_v = dpend; rs.div_rd = drd; rs.div_d = dd;
            rs.fpu_v  = 1'($urandom_range(0, 1));
            rs.fpu_rd = 5'($urandom_range(0, 7));
            rs.fpu_d  = $urandom;
            if (!full_m && ($urandom_range(0, 1) == 1)) begin
                rs.ld_v  = 1'b1;
                rs.ld_rd = 5'($urandom_range(0, 7));
                rs.ld_d  = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                rs.iss_rd = 5'($urandom_range(0, 31));
                rs.iss_v  = !busy_m[rs.iss_rd];
            end

            m_empty = (mq.size() == 0);
            m_dpref = rs.div_v && ((starve_m == STARVE) || m_empty);
            m_lpref = !m_empty && !m_dpref;
            m_rd    = m_dpref ? rs.div_rd : (m_empty ? 5'd0 : mq[0].rd);
            m_conf  = rs.fpu_v && (m_dpref || m_lpref) && (m_rd == rs.fpu_rd);
            m_dwin  = m_dpref && !m_conf;
            m_lwin  = m_lpref && !m_conf;

            drive(rs);
            #1;
            chk("rnd div_ready", 32'(div_ready), 32'(m_dwin));
            @(posedge clk);
            #1;

            if (pw0) busy_m[pa0] = 1'b0;
            if (pw1) busy_m[pa1] = 1'b0;
            if (rs.iss_v) busy_m[rs.iss_rd] = 1'b1;
            pw0 = rs.fpu_v;
            if (rs.fpu_v) begin pa0 = rs.fpu_rd; pd0 = rs.fpu_d; end
            pw1 = m_dwin || m_lwin;
            if (m_dwin) begin pa1 = rs.div_rd; pd1 = rs.div_d; dpend = 0; end
            if (m_lwin) begin pa1 = mq[0].rd; pd1 = mq[0].data; void'(mq.pop_front()); end
            if (rs.ld_v) begin
                if (mq.size() < DEPTH) begin
                    ment.rd = rs.ld_rd; ment.data = rs.ld_d;
                    mq.push_back(ment);
                end else begin
                    ovf_m = 1;
                end
            end
            if (rs.div_v && !m_dwin) starve_m = (starve_m + 1 > STARVE) ? STARVE : starve_m + 1;
            else starve_m = 0;
            full_m = (mq.size() == DEPTH);

            chk("rnd wen0", 32'(wen0), 32'(pw0));
            if (pw0) begin
                chk("rnd waddr0", 32'(waddr0), 32'(pa0));
                chk("rnd wd0", wd0, pd0);
            end
            chk("rnd wen1", 32'(wen1), 32'(pw1));
            if (pw1) begin
                chk("rnd waddr1", 32'(waddr1), 32'(pa1));
                chk("rnd wd1", wd1, pd1);
            end
            chk("rnd busy", fpr_busy, busy_m);
            chk("rnd ld_full", 32'(ld_full), 32'(full_m));
            chk("rnd overflow", 32'(ldq_overflow), 32'(ovf_m));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
